// File: rtl/zap_wb_walk_arbiter.sv
// zap_wb_walk_arbiter: shares one Wishbone B3 port between the TLB walker and the cache FSM.
// Optional stall timeout with an error pulse to the owner: define ZAP_WB_ARB_TIMEOUT_EN.
module zap_wb_walk_arbiter #(
    parameter logic [31:0] TIMEOUT_CYCLES = 32'd1024
) (
    input  logic        i_clk,
    input  logic        i_reset,

    input  logic        i_walk_cyc_nxt,
    input  logic        i_walk_stb_nxt,
    input  logic [31:0] i_walk_adr_nxt,
    input  logic [3:0]  i_walk_sel_nxt,

    input  logic        i_cache_cyc_nxt,
    input  logic        i_cache_stb_nxt,
    input  logic        i_cache_wen_nxt,
    input  logic [31:0] i_cache_adr_nxt,
    input  logic [3:0]  i_cache_sel_nxt,
    input  logic [31:0] i_cache_dat_nxt,

    output logic        o_walk_ack,
    output logic        o_cache_ack,
    output logic        o_walk_err,
    output logic        o_cache_err,
    output logic [31:0] o_wb_rdat,

    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [31:0] o_wb_adr,
    output logic [3:0]  o_wb_sel,
    output logic [31:0] o_wb_dat,
    input  logic [31:0] i_wb_dat,
    input  logic        i_wb_ack
);

    typedef enum logic [1:0] {
        IDLE,
        GNT_WALK,
        GNT_CACHE
    } state_t;

    state_t state;
    logic   last_gnt;
    logic   tmo_hit;

    assign o_wb_rdat   = i_wb_dat;
    assign o_walk_ack  = i_wb_ack & (state == GNT_WALK) & o_wb_stb;
    assign o_cache_ack = i_wb_ack & (state == GNT_CACHE) & o_wb_stb;

`ifdef ZAP_WB_ARB_TIMEOUT_EN
    logic [31:0] tmo_cnt;

    assign tmo_hit = (state != IDLE) & o_wb_stb & ~i_wb_ack &
                     (tmo_cnt == TIMEOUT_CYCLES - 32'd1);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            tmo_cnt <= '0;
        end else if (state == IDLE || i_wb_ack || tmo_hit) begin
            tmo_cnt <= '0;
        end else if (o_wb_stb) begin
            tmo_cnt <= tmo_cnt + 32'd1;
        end
    end

    assign o_walk_err  = tmo_hit & (state == GNT_WALK);
    assign o_cache_err = tmo_hit & (state == GNT_CACHE);
`else
    logic unused_tmo;

    assign unused_tmo  = |TIMEOUT_CYCLES;
    assign tmo_hit     = 1'b0;
    assign o_walk_err  = 1'b0;
    assign o_cache_err = 1'b0;
`endif

    // Bus fields default to 0 each edge; only the owner's _nxt values override.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state    <= IDLE;
            last_gnt <= 1'b1;
            o_wb_cyc <= 1'b0;
            o_wb_stb <= 1'b0;
            o_wb_we  <= 1'b0;
            o_wb_adr <= '0;
            o_wb_sel <= '0;
            o_wb_dat <= '0;
        end else begin
            o_wb_cyc <= 1'b0;
            o_wb_stb <= 1'b0;
            o_wb_we  <= 1'b0;
            o_wb_adr <= '0;
            o_wb_sel <= '0;
            o_wb_dat <= '0;
            unique case (state)
                IDLE: begin
                    if (i_walk_cyc_nxt && (!i_cache_cyc_nxt || last_gnt)) begin
                        state    <= GNT_WALK;
                        o_wb_cyc <= 1'b1;
                        o_wb_stb <= i_walk_stb_nxt;
                        o_wb_adr <= i_walk_adr_nxt;
                        o_wb_sel <= i_walk_sel_nxt;
                    end else if (i_cache_cyc_nxt) begin
                        state    <= GNT_CACHE;
                        o_wb_cyc <= 1'b1;
                        o_wb_stb <= i_cache_stb_nxt;
                        o_wb_we  <= i_cache_wen_nxt;
                        o_wb_adr <= i_cache_adr_nxt;
                        o_wb_sel <= i_cache_sel_nxt;
                        o_wb_dat <= i_cache_dat_nxt;
                    end
                end
                GNT_WALK: begin
                    if (tmo_hit || !i_walk_cyc_nxt) begin
                        state    <= IDLE;
                        last_gnt <= 1'b0;
                    end else begin
                        o_wb_cyc <= 1'b1;
                        o_wb_stb <= i_walk_stb_nxt;
                        o_wb_adr <= i_walk_adr_nxt;
                        o_wb_sel <= i_walk_sel_nxt;
                    end
                end
                GNT_CACHE: begin
                    if (tmo_hit || !i_cache_cyc_nxt) begin
                        state    <= IDLE;
                        last_gnt <= 1'b1;
                    end else begin
                        o_wb_cyc <= 1'b1;
                        o_wb_stb <= i_cache_stb_nxt;
                        o_wb_we  <= i_cache_wen_nxt;
                        o_wb_adr <= i_cache_adr_nxt;
                        o_wb_sel <= i_cache_sel_nxt;
                        o_wb_dat <= i_cache_dat_nxt;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_zap_wb_walk_arbiter.sv
// tb_zap_wb_walk_arbiter: directed checks of grant, ack routing, round-robin,
// reset and (with ZAP_WB_ARB_TIMEOUT_EN) the stall timeout.
module tb_zap_wb_walk_arbiter;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_walk_cyc_nxt;
    logic        i_walk_stb_nxt;
    logic [31:0] i_walk_adr_nxt;
    logic [3:0]  i_walk_sel_nxt;
    logic        i_cache_cyc_nxt;
    logic        i_cache_stb_nxt;
    logic        i_cache_wen_nxt;
    logic [31:0] i_cache_adr_nxt;
    logic [3:0]  i_cache_sel_nxt;
    logic [31:0] i_cache_dat_nxt;
    logic        o_walk_ack;
    logic        o_cache_ack;
    logic        o_walk_err;
    logic        o_cache_err;
    logic [31:0] o_wb_rdat;
    logic        o_wb_cyc;
    logic        o_wb_stb;
    logic        o_wb_we;
    logic [31:0] o_wb_adr;
    logic [3:0]  o_wb_sel;
    logic [31:0] o_wb_dat;
    logic [31:0] i_wb_dat;
    logic        i_wb_ack;

    int checks   = 0;
    int failures = 0;

    always #5 i_clk = ~i_clk;

    zap_wb_walk_arbiter #(
        .TIMEOUT_CYCLES(32'd8)
    ) dut (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_walk_cyc_nxt  (i_walk_cyc_nxt),
        .i_walk_stb_nxt  (i_walk_stb_nxt),
        .i_walk_adr_nxt  (i_walk_adr_nxt),
        .i_walk_sel_nxt  (i_walk_sel_nxt),
        .i_cache_cyc_nxt (i_cache_cyc_nxt),
        .i_cache_stb_nxt (i_cache_stb_nxt),
        .i_cache_wen_nxt (i_cache_wen_nxt),
        .i_cache_adr_nxt (i_cache_adr_nxt),
        .i_cache_sel_nxt (i_cache_sel_nxt),
        .i_cache_dat_nxt (i_cache_dat_nxt),
        .o_walk_ack      (o_walk_ack),
        .o_cache_ack     (o_cache_ack),
        .o_walk_err      (o_walk_err),
        .o_cache_err     (o_cache_err),
        .o_wb_rdat       (o_wb_rdat),
        .o_wb_cyc        (o_wb_cyc),
        .o_wb_stb        (o_wb_stb),
        .o_wb_we         (o_wb_we),
        .o_wb_adr        (o_wb_adr),
        .o_wb_sel        (o_wb_sel),
        .o_wb_dat        (o_wb_dat),
        .i_wb_dat        (i_wb_dat),
        .i_wb_ack        (i_wb_ack)
    );

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_bus_zero(input string tag);
        chk({tag, "_cyc"}, {31'd0, o_wb_cyc}, 32'd0);
        chk({tag, "_stb"}, {31'd0, o_wb_stb}, 32'd0);
        chk({tag, "_we"},  {31'd0, o_wb_we},  32'd0);
        chk({tag, "_adr"}, o_wb_adr, 32'd0);
        chk({tag, "_sel"}, {28'd0, o_wb_sel}, 32'd0);
        chk({tag, "_dat"}, o_wb_dat, 32'd0);
    endtask

    task automatic walk_req(input logic [31:0] adr);
        i_walk_cyc_nxt = 1'b1;
        i_walk_stb_nxt = 1'b1;
        i_walk_adr_nxt = adr;
        i_walk_sel_nxt = 4'hF;
    endtask

    task automatic walk_drop();
        i_walk_cyc_nxt = 1'b0;
        i_walk_stb_nxt = 1'b0;
        i_walk_adr_nxt = 32'd0;
        i_walk_sel_nxt = 4'h0;
    endtask

    task automatic cache_req(input logic [31:0] adr, input logic we,
                             input logic [31:0] dat);
        i_cache_cyc_nxt = 1'b1;
        i_cache_stb_nxt = 1'b1;
        i_cache_wen_nxt = we;
        i_cache_adr_nxt = adr;
        i_cache_sel_nxt = 4'hF;
        i_cache_dat_nxt = dat;
    endtask

    task automatic cache_drop();
        i_cache_cyc_nxt = 1'b0;
        i_cache_stb_nxt = 1'b0;
        i_cache_wen_nxt = 1'b0;
        i_cache_adr_nxt = 32'd0;
        i_cache_sel_nxt = 4'h0;
        i_cache_dat_nxt = 32'd0;
    endtask

    task automatic do_reset();
        walk_drop();
        cache_drop();
        i_wb_ack = 1'b0;
        i_reset  = 1'b1;
        tick();
        i_reset  = 1'b0;
    endtask

    initial begin
        i_reset  = 1'b1;
        i_wb_ack = 1'b0;
        i_wb_dat = 32'd0;
        walk_drop();
        cache_drop();
        tick();
        tick();
        i_reset = 1'b0;
        #1;
        chk_bus_zero("reset");
        chk("reset_wack", {31'd0, o_walk_ack}, 32'd0);
        chk("reset_cack", {31'd0, o_cache_ack}, 32'd0);
        chk("reset_werr", {31'd0, o_walk_err}, 32'd0);
        chk("reset_cerr", {31'd0, o_cache_err}, 32'd0);

        // Walker-only read, slave acks on the third bus cycle
        walk_req(32'h0000_4008);
        #1;
        chk("w1_pre_cyc", {31'd0, o_wb_cyc}, 32'd0);
        tick();
        chk("w1_cyc", {31'd0, o_wb_cyc}, 32'd1);
        chk("w1_stb", {31'd0, o_wb_stb}, 32'd1);
        chk("w1_adr", o_wb_adr, 32'h0000_4008);
        chk("w1_sel", {28'd0, o_wb_sel}, 32'hF);
        chk("w1_we", {31'd0, o_wb_we}, 32'd0);
        chk("w1_wack_c1", {31'd0, o_walk_ack}, 32'd0);
        tick();
        chk("w1_wack_c2", {31'd0, o_walk_ack}, 32'd0);
        tick();
        i_wb_dat = 32'hDEAD_BEEF;
        i_wb_ack = 1'b1;
        #1;
        chk("w1_wack_c3", {31'd0, o_walk_ack}, 32'd1);
        chk("w1_cack_c3", {31'd0, o_cache_ack}, 32'd0);
        chk("w1_rdat", o_wb_rdat, 32'hDEAD_BEEF);
        walk_drop();
        tick();
        i_wb_ack = 1'b0;
        #1;
        chk("w1_end_cyc", {31'd0, o_wb_cyc}, 32'd0);
        chk("w1_end_wack", {31'd0, o_walk_ack}, 32'd0);

        // Simultaneous request after reset: walker first, then cache after IDLE
        do_reset();
        walk_req(32'h0000_4010);
        cache_req(32'h0000_2000, 1'b0, 32'd0);
        tick();
        chk("both_w_adr", o_wb_adr, 32'h0000_4010);
        chk("both_w_cyc", {31'd0, o_wb_cyc}, 32'd1);
        i_wb_ack = 1'b1;
        #1;
        chk("both_wack", {31'd0, o_walk_ack}, 32'd1);
        chk("both_cack0", {31'd0, o_cache_ack}, 32'd0);
        walk_drop();
        tick();
        i_wb_ack = 1'b0;
        chk("both_gap_cyc", {31'd0, o_wb_cyc}, 32'd0);
        tick();
        chk("both_c_adr", o_wb_adr, 32'h0000_2000);
        chk("both_c_cyc", {31'd0, o_wb_cyc}, 32'd1);
        i_wb_ack = 1'b1;
        #1;
        chk("both_cack", {31'd0, o_cache_ack}, 32'd1);
        chk("both_wack0", {31'd0, o_walk_ack}, 32'd0);
        cache_drop();
        tick();
        i_wb_ack = 1'b0;

        // Cache 4-beat burst write with the walker arriving mid-burst
        cache_req(32'h0000_0100, 1'b1, 32'h0000_00A0);
        tick();
        chk("burst_adr0", o_wb_adr, 32'h0000_0100);
        chk("burst_we0", {31'd0, o_wb_we}, 32'd1);
        chk("burst_dat0", o_wb_dat, 32'h0000_00A0);
        i_wb_ack = 1'b1;
        walk_req(32'h0000_5000);
        for (int b = 1; b < 4; b++) begin
            cache_req(32'h0000_0100 + 32'(4 * b), 1'b1, 32'h0000_00A0 + 32'(b));
            #1;
            chk("burst_cack", {31'd0, o_cache_ack}, 32'd1);
            chk("burst_wack", {31'd0, o_walk_ack}, 32'd0);
            tick();
            chk("burst_adr", o_wb_adr, 32'h0000_0100 + 32'(4 * b));
            chk("burst_cyc", {31'd0, o_wb_cyc}, 32'd1);
            chk("burst_dat", o_wb_dat, 32'h0000_00A0 + 32'(b));
        end
        #1;
        chk("burst_cack3", {31'd0, o_cache_ack}, 32'd1);
        cache_drop();
        tick();
        i_wb_ack = 1'b0;
        chk("burst_gap_cyc", {31'd0, o_wb_cyc}, 32'd0);
        i_wb_ack = 1'b1;
        #1;
        chk("idle_ack_w", {31'd0, o_walk_ack}, 32'd0);
        chk("idle_ack_c", {31'd0, o_cache_ack}, 32'd0);
        i_wb_ack = 1'b0;
        tick();
        chk("burst_w_adr", o_wb_adr, 32'h0000_5000);
        chk("burst_w_cyc", {31'd0, o_wb_cyc}, 32'd1);
        chk("burst_w_we", {31'd0, o_wb_we}, 32'd0);
        chk("burst_w_dat", o_wb_dat, 32'd0);
        i_wb_ack = 1'b1;
        #1;
        chk("burst_w_ack", {31'd0, o_walk_ack}, 32'd1);
        walk_drop();
        tick();
        i_wb_ack = 1'b0;

        // Three rounds of contention: W C W C W C
        do_reset();
        walk_req(32'h0000_4000);
        cache_req(32'h0000_2000, 1'b0, 32'd0);
        tick();
        for (int r = 0; r < 6; r++) begin
            chk("rr_adr", o_wb_adr,
                (r % 2 == 0) ? 32'h0000_4000 : 32'h0000_2000);
            i_wb_ack = 1'b1;
            #1;
            chk("rr_ack", {30'd0, o_cache_ack, o_walk_ack},
                (r % 2 == 0) ? 32'd1 : 32'd2);
            if (r % 2 == 0) walk_drop();
            else cache_drop();
            tick();
            i_wb_ack = 1'b0;
            chk("rr_gap", {31'd0, o_wb_cyc}, 32'd0);
            if (r == 5) walk_drop();
            else if (r % 2 == 0) walk_req(32'h0000_4000);
            else cache_req(32'h0000_2000, 1'b0, 32'd0);
            tick();
        end
        chk("rr_end_cyc", {31'd0, o_wb_cyc}, 32'd0);

        // Reset while the cache owns the bus with stb high
        cache_req(32'h0000_3000, 1'b1, 32'h0000_0055);
        tick();
        chk("rst_pre_cyc", {31'd0, o_wb_cyc}, 32'd1);
        i_reset = 1'b1;
        tick();
        chk_bus_zero("rst_mid");
        i_wb_ack = 1'b1;
        #1;
        chk("rst_late_cack", {31'd0, o_cache_ack}, 32'd0);
        chk("rst_late_wack", {31'd0, o_walk_ack}, 32'd0);
        i_reset  = 1'b0;
        i_wb_ack = 1'b0;
        cache_drop();
        tick();

`ifdef ZAP_WB_ARB_TIMEOUT_EN
        // Walker read never acked; pending cache request follows the timeout
        walk_req(32'h0000_4020);
        cache_req(32'h0000_2040, 1'b0, 32'd0);
        tick();
        chk("tmo_w_adr", o_wb_adr, 32'h0000_4020);
        for (int k = 1; k < 8; k++) begin
            chk("tmo_err_early", {31'd0, o_walk_err}, 32'd0);
            tick();
        end
        chk("tmo_werr", {31'd0, o_walk_err}, 32'd1);
        chk("tmo_cerr", {31'd0, o_cache_err}, 32'd0);
        walk_drop();
        tick();
        chk("tmo_cyc_off", {31'd0, o_wb_cyc}, 32'd0);
        chk("tmo_werr_off", {31'd0, o_walk_err}, 32'd0);
        tick();
        chk("tmo_c_adr", o_wb_adr, 32'h0000_2040);
        chk("tmo_c_cyc", {31'd0, o_wb_cyc}, 32'd1);
        i_wb_ack = 1'b1;
        #1;
        chk("tmo_cack", {31'd0, o_cache_ack}, 32'd1);
        cache_drop();
        tick();
        i_wb_ack = 1'b0;
`else
        // Without the timeout a stalled owner keeps the bus indefinitely
        walk_req(32'h0000_4020);
        tick();
        for (int k = 0; k < 10; k++) begin
            chk("stall_werr", {31'd0, o_walk_err}, 32'd0);
            tick();
        end
        chk("stall_cyc", {31'd0, o_wb_cyc}, 32'd1);
        chk("stall_adr", o_wb_adr, 32'h0000_4020);
        walk_drop();
        tick();
        chk("stall_end_cyc", {31'd0, o_wb_cyc}, 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/zap_wb_walk_arbiter.md
# zap_wb_walk_arbiter

Two-master Wishbone B3 arbiter that shares the core's single memory port between the page-table walker (TLB FSM) and the cache line-fill/writeback FSM. Both masters present next-cycle (`_nxt`) bus values; the arbiter grants one master, registers the grantee's values onto the bus, and routes ack/data back. Grant is held for the whole cycle (`cyc`) and alternates round-robin when both masters contend.

## Interface
- `TIMEOUT_CYCLES`, default 32'd1024: stall cycles tolerated before forced release (only with `ZAP_WB_ARB_TIMEOUT_EN`).
- `i_clk` in 1: clock.
- `i_reset` in 1: synchronous, active-high reset.
- `i_walk_cyc_nxt`, `i_walk_stb_nxt` in 1 each: walker next-cycle `cyc`/`stb`.
- `i_walk_adr_nxt` in 32, `i_walk_sel_nxt` in 4: walker next address and select. Walker is read-only.
- `i_cache_cyc_nxt`, `i_cache_stb_nxt`, `i_cache_wen_nxt` in 1 each: cache next-cycle `cyc`/`stb`/`we`.
- `i_cache_adr_nxt` in 32, `i_cache_sel_nxt` in 4, `i_cache_dat_nxt` in 32: cache next address, select and write data.
- `o_walk_ack`, `o_cache_ack` out 1 each: ack routed to the owner only.
- `o_walk_err`, `o_cache_err` out 1 each: timeout error to the owner. Tied 0 when the feature is off.
- `o_wb_rdat` out 32: `i_wb_dat` broadcast to both masters.
- `o_wb_cyc`, `o_wb_stb`, `o_wb_we` out 1 each: registered bus controls.
- `o_wb_adr` out 32, `o_wb_sel` out 4, `o_wb_dat` out 32: registered bus address, select and write data.
- `i_wb_dat` in 32, `i_wb_ack` in 1: slave read data and acknowledge.

## Operation
- States: `IDLE`, `GNT_WALK`, `GNT_CACHE`. A 1-bit `last_gnt` register holds 0 for walk and 1 for cache.
- `IDLE`:
  - Only one `cyc_nxt` set: go to that master's grant state.
  - Both set: grant the master that is not `last_gnt`.
  - On grant, that master's `_nxt` values are registered onto the bus in the same edge, so no cycle is added to the master's own path.
  - Neither set: bus outputs register 0.
- `GNT_x`: every cycle the bus registers the owner's `_nxt` fields.
  - Owner `cyc_nxt` = 0: register 0 on all bus outputs, set `last_gnt` to the owner, go to `IDLE`.
  - The other master may hold `cyc_nxt` = 1 meanwhile. It is not forwarded and receives no ack; it keeps holding its request.
- Ack routing is combinational: `o_walk_ack = i_wb_ack & (state==GNT_WALK) & o_wb_stb`. `o_cache_ack` is the same with `GNT_CACHE`.
- Walker path forces `o_wb_we` = 0 and `o_wb_dat` = 0.
- An `i_wb_ack` seen in `IDLE` is dropped and goes to no master.

## Timing
- Reset values: state `IDLE`, `last_gnt` = 1 (walker wins first contention), timeout counter 0, and all `o_wb_*` = 0. All `o_*_ack`/`o_*_err` = 0 combinationally, because the state is `IDLE`.
- Latency: request to bus is 1 edge with no contention. A blocked master is granted 1 cycle after the owner drops `cyc_nxt`, because the `IDLE` cycle is mandatory. This gives a bus gap of at least 1 cycle between owners.
- Back-to-back requests by the same master with no contender still pass through `IDLE`: one idle bus cycle.
- Reset mid-transfer: the bus drops to 0 on the next edge and any in-flight ack is ignored.
- A simultaneous drop by the owner and a rise by the other master resolves in `IDLE` on the next cycle.

## Configuration
- `ZAP_WB_ARB_TIMEOUT_EN` defined:
  - A counter increments on each grant-state cycle with `o_wb_stb`=1 and `i_wb_ack`=0, and clears on ack or on `IDLE`.
  - When it reaches `TIMEOUT_CYCLES-1`, the arbiter pulses the owner's `o_*_err` for one cycle (combinational, that cycle) and registers 0 on all bus outputs.
  - It then sets `last_gnt` to the owner and goes to `IDLE`. The master must drop `cyc_nxt` on err.
- Not defined: no counter, err outputs tied 0, and the parameter is unused.

## Test plan
- Walker-only read at adr 0x0000_4008, sel 0xF, ack after 3 cycles:
  - `o_wb_cyc` rises 1 edge after `i_walk_cyc_nxt`.
  - `o_walk_ack` = 1 exactly once and `o_cache_ack` stays 0.
  - `o_wb_rdat` = `i_wb_dat` = 0xDEAD_BEEF.
- Both request in the same cycle after reset:
  - Walker is granted first, the cache waits.
  - After the walker drops `cyc`: one `IDLE` cycle, then the cache adr appears on the bus.
- Cache 4-beat burst write 0x100–0x10C with the walker arriving mid-burst:
  - `cyc` stays asserted with no walker address on the bus until the cache drops `cyc_nxt`.
  - The walker is granted 2 cycles after that.
- Repeated contention over 3 rounds: grants alternate W, C, W, C, W, C.
- Reset asserted while in `GNT_CACHE` with stb high:
  - Next edge: all `o_wb_*` = 0 and state `IDLE`.
  - A late ack does not reach either master.
- With `ZAP_WB_ARB_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8, and a slave that never acks a walker read:
  - `o_walk_err` pulses once on the 8th stalled cycle and `o_wb_cyc` = 0 on the next edge.
  - A pending cache request is then granted.
